spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
// - Initiator end of the team's 4-wire SPI link; drives CS/SCK/MOSI, samples MISO.
// - Runs one DATA_W-bit full-duplex frame per start request, in any CPOL/CPHA mode,
//   MSB- or LSB-first.
// - CS is active-high; pins connect directly to the SPI_slave CS/SCK/MOSI/MISO.
// PARAMETERS
// - DATA_W   8  frame length in bits (>=2)
// - HALF     4  SCK half-period in clk_i cycles (>=2)
// PORTS
// - clk_i    in   1       system clock, single domain
// - rst_i    in   1       asynchronous, active-low reset
// - ena_i    in   1       global enable; low freezes divider and FSM, start ignored
// - start_i  in   1       request frame; accepted only in IDLE with ena_i=1
// - tx_data  in   DATA_W  frame to send, latched on accept
// - MSB      in   1       1 = MSB first; latched on accept
// - CPOL     in   1       SCK idle level; latched on accept
// - CPHA     in   1       0 = sample on leading edge, 1 = sample on trailing edge; latched on accept
// - busy     out  1       high from accept cycle+1 until done cycle inclusive
// - done     out  1       one-cycle pulse, frame complete
// - rx_data  out  DATA_W  received frame; valid from done cycle, held until next done
// - CS       out  1       chip select, active-high
// - SCK      out  1       serial clock
// - MOSI     out  1       serial data out
// - MISO     in   1       serial data in
// BEHAVIOUR
// - Reset (rst_i=0, immediate):
//   - FSM=IDLE; CS=0, SCK=0, MOSI=0, busy=0, done=0, rx_data=0.
//   - Latched mode/shift registers cleared.
//   - Mid-frame reset aborts the frame; no done pulse.
// - FSM: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
// - IDLE: CS=0; SCK <= CPOL input each cycle (1-cycle lag).
//   - start_i && ena_i in cycle T: latch inputs; at T+1 CS=1, busy=1, enter LEAD.
// - LEAD: HALF cycles; if CPHA=0, MOSI presents bit 0 of the frame order at T+1.
// - XFER: 2*DATA_W SCK toggles, edge k (k=0..2W-1) at T+1+HALF*(k+1).
//   - Even k = leading edge; odd k = trailing edge.
//   - CPHA=0: sample MISO on even k; shift MOSI on odd k except the last edge.
//   - CPHA=1: shift MOSI on even k (first bit at k=0); sample MISO on odd k.
//   - Sample captures the MISO value registered in the edge cycle.
// - TRAIL: HALF cycles after the last edge; SCK rests at the latched CPOL.
//   - At T+1+(2W+1)*HALF: CS=0, done=1, rx_data updated, busy=1 for that cycle only.
//   - Next cycle: IDLE, busy=0.
// - Bit order: MSB=1 sends/assembles bit W-1 first; MSB=0 bit 0 first.
//   - rx_data uses the same order as tx.
// - start_i while not IDLE: ignored, not queued; earliest restart is the cycle after done.
// - ena_i=0 mid-frame:
//   - All counters, SCK, MOSI and CS hold; resumes exactly where stopped.
//   - Frame stretched by the number of disabled cycles.
// - CPOL/CPHA/MSB/tx_data changes during a frame: no effect.
// TESTING
// - Mode 0, MSB, tx=0xA5, MISO looped from MOSI, start at T:
//   - CS high T+1..T+68; 8 rising edges; MOSI 1,0,1,0,0,1,0,1.
//   - done at T+69; rx_data=0xA5.
// - Mode 3, LSB, tx=0x3C, slave model returns 0x96 LSB-first:
//   - rx_data=0x96; SCK idles high; model captures 0x3C.
// - Modes 1 and 2, MSB, tx=0xF0, slave returns 0x0F:
//   - rx_data=0x0F; exactly 16 SCK toggles per frame.
// - start_i held high for 3 frames:
//   - Frames separated by >=1 IDLE cycle.
//   - start pulsed at T+20 mid-frame: no extra frame.
// - ena_i low 10 cycles at T+30 (mode 0, tx=0x5A):
//   - SCK/MOSI/CS frozen; done at T+79; rx correct.
// - rst_i low at T+25:
//   - CS=0, SCK=0, busy=0 immediately; no done.
//   - After release, new frame 0x81 completes normally.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator: one DATA_W-bit full-duplex frame per accepted start, any
// CPOL/CPHA mode, MSB- or LSB-first. CS is active-high.
module spi_master #(
  parameter int DATA_W = 8,
  parameter int HALF   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              MSB,
  input  logic              CPOL,
  input  logic              CPHA,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              CS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     ecnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              msb_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              tick;
  logic              sample_edge;
  logic              shift_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic msb_first);
    return msb_first ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                  input logic msb_first);
    return msb_first ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
  endfunction

  // Divider terminal count and the role of the upcoming SCK edge.
  // Even edge index = leading edge. With CPHA=0 the first bit is already on
  // MOSI before edge 0, so the final trailing edge has nothing left to shift.
  always_comb begin
    tick        = (cnt == HALF_M1);
    sample_edge = cpha_q ? ecnt[0] : ~ecnt[0];
    shift_edge  = cpha_q ? ~ecnt[0] : (ecnt[0] && (ecnt != LAST_EDGE));
  end

  // Frame sequencer with registered pin outputs; ena_i=0 freezes it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ecnt    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      msb_q   <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      CS      <= 1'b0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      // done and the trailing busy cycle are single-cycle regardless of ena_i
      done <= 1'b0;
      if (state == IDLE) busy <= 1'b0;
      if (ena_i) begin
        unique case (state)
          IDLE: begin
            CS  <= 1'b0;
            SCK <= CPOL;
            // busy still high here means this is the done cycle: no restart yet
            if (start_i && !busy) begin
              state  <= LEAD;
              busy   <= 1'b1;
              CS     <= 1'b1;
              cnt    <= '0;
              ecnt   <= '0;
              msb_q  <= MSB;
              cpol_q <= CPOL;
              cpha_q <= CPHA;
              rx_sr  <= '0;
              if (!CPHA) begin
                MOSI  <= first_bit(tx_data, MSB);
                tx_sr <= shift_out(tx_data, MSB);
              end else begin
                tx_sr <= tx_data;
              end
            end
          end
          LEAD, XFER: begin
            if (tick) begin
              cnt <= '0;
              SCK <= ~SCK;
              if (sample_edge)
                rx_sr <= msb_q ? {rx_sr[DATA_W-2:0], MISO} : {MISO, rx_sr[DATA_W-1:1]};
              if (shift_edge) begin
                MOSI  <= first_bit(tx_sr, msb_q);
                tx_sr <= shift_out(tx_sr, msb_q);
              end
              if (ecnt == LAST_EDGE) begin
                state <= TRAIL;
              end else begin
                ecnt  <= ecnt + 1'b1;
                state <= XFER;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TRAIL: begin
            if (tick) begin
              state   <= IDLE;
              cnt     <= '0;
              ecnt    <= '0;
              CS      <= 1'b0;
              SCK     <= cpol_q;
              done    <= 1'b1;
              rx_data <= rx_sr;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a behavioural SPI slave answers each frame,
// the driver queues the expected outcome, and a monitor checks every done.
module tb_spi_master;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ena_i;
  logic       start_i;
  logic [7:0] tx_data;
  logic       MSB;
  logic       CPOL;
  logic       CPHA;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       CS;
  logic       SCK;
  logic       MOSI;
  logic       MISO;

  spi_master #(.DATA_W(8), .HALF(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .start_i(start_i),
    .tx_data(tx_data), .MSB(MSB), .CPOL(CPOL), .CPHA(CPHA),
    .busy(busy), .done(done), .rx_data(rx_data),
    .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- behavioural slave ----------------
  logic [7:0] s_resp;
  logic       s_cpol, s_cpha, s_msb, loop_en;
  logic       miso_s = 1'b0;
  logic [7:0] s_cap;
  int         s_bit, s_rc, tog;
  logic       lead;

  assign MISO = loop_en ? MOSI : miso_s;

  task automatic s_drive();
    if (s_bit < 8) begin
      miso_s = s_msb ? s_resp[7 - s_bit] : s_resp[s_bit];
      s_bit++;
    end
  endtask

  always @(posedge CS) begin
    s_bit = 0;
    s_rc  = 0;
    s_cap = '0;
    tog   = 0;
    if (!s_cpha) s_drive();
  end

  // Leading edge = SCK leaves its idle level; sample on leading for CPHA=0,
  // on trailing for CPHA=1, and present the next bit on the other edge.
  always @(SCK) begin
    if (CS === 1'b1) begin
      tog++;
      lead = (SCK != s_cpol);
      if (lead ^ s_cpha) begin
        if (s_rc < 8) begin
          if (s_msb) s_cap[7 - s_rc] = MOSI;
          else       s_cap[s_rc]     = MOSI;
          s_rc++;
        end
      end else begin
        s_drive();
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] rx;
    logic [7:0] cap;
    int         dcyc;
    int         cs;
  } exp_t;
  exp_t exp_q[$];
  int   cs_cnt = 0;

  always @(negedge clk_i) begin
    if (CS === 1'b1) cs_cnt++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 expected no frame (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data",    rx_data, e.rx);
        chk("slave_cap",  s_cap,   e.cap);
        chk("done_cycle", cyc,     e.dcyc);
        chk("cs_length",  cs_cnt,  e.cs);
        chk("sck_toggles", tog,    16);
      end
      cs_cnt = 0;
    end
  end

  always @(posedge CS) cs_cnt = 0;

  // ---------------- driver ----------------
  task automatic set_mode(input logic [7:0] tx, input logic [7:0] resp, input logic cpol,
                          input logic cpha, input logic msb, input logic lp);
    tx_data = tx;  MSB = msb;  CPOL = cpol;  CPHA = cpha;
    s_resp  = resp; s_cpol = cpol; s_cpha = cpha; s_msb = msb; loop_en = lp;
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] resp, input logic cpol,
                           input logic cpha, input logic msb, input logic lp,
                           input int ena_at, input int pulse_at);
    int   t;
    int   stretch;
    bit   seen;
    bit   frz_ok;
    logic [2:0] snap;
    @(negedge clk_i);
    set_mode(tx, resp, cpol, cpha, msb, lp);
    @(negedge clk_i);
    start_i = 1'b1;
    t = cyc;
    stretch = (ena_at != 0) ? 10 : 0;
    exp_q.push_back('{rx: (lp ? tx : resp), cap: tx, dcyc: t + 69 + stretch, cs: 68 + stretch});
    @(negedge clk_i);
    start_i = 1'b0;
    // inputs changed mid-frame must not affect the frame in flight
    tx_data = ~tx; MSB = ~msb; CPHA = ~cpha;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_i);
      start_i = (pulse_at != 0) && (cyc == t + pulse_at);
      if (ena_at != 0 && cyc == t + ena_at) begin
        ena_i  = 1'b0;
        snap   = {SCK, MOSI, CS};
        frz_ok = 1;
        repeat (10) begin
          @(negedge clk_i);
          if ({SCK, MOSI, CS} != snap) frz_ok = 0;
        end
        ena_i = 1'b1;
        chk("freeze_hold", frz_ok, 1);
      end
      if (done === 1'b1) seen = 1;
    end
    start_i = 1'b0;
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout: got no done expected done by cycle %0d", t + 69 + stretch);
    end
    repeat (2) @(negedge clk_i);
    chk("idle_sck", SCK, cpol);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int   t;
    bit   quiet;
    rst_i = 1'b0; ena_i = 1'b1; start_i = 1'b0;
    set_mode(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("rst_cs", CS, 0);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // mode 0 loopback, MSB first
    run_frame(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    // mode 3, LSB first
    run_frame(8'h3C, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    // modes 1 and 2, MSB first
    run_frame(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run_frame(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    // enable dropped for 10 cycles mid-frame
    run_frame(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 30, 0);
    // stray start pulse mid-frame must not queue a second frame
    run_frame(8'h69, 8'h2D, 1'b0, 1'b0, 1'b1, 1'b0, 0, 20);
    quiet = 1;
    repeat (80) begin
      @(negedge clk_i);
      if (CS !== 1'b0) quiet = 0;
    end
    chk("no_extra_frame", quiet, 1);

    // start held high: back-to-back frames, restart one cycle after done
    @(negedge clk_i);
    set_mode(8'hB4, 8'h4B, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{rx: 8'h4B, cap: 8'hB4, dcyc: t + 70 * k + 69, cs: 68});
    repeat (209) @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("held_frames_done", exp_q.size(), 0);
    chk("held_no_fourth", CS, 0);

    // asynchronous reset mid-frame aborts without done
    @(negedge clk_i);
    set_mode(8'h3C, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (23) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_cs", CS, 0);
    chk("midrst_sck", SCK, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx", rx_data, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (80) @(negedge clk_i);
    run_frame(8'h81, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // randomized frames across all modes and bit orders
    for (int n = 0; n < 10; n++) begin
      logic [7:0] rtx, rrs;
      logic [3:0] rb;
      rtx = 8'($urandom);
      rrs = 8'($urandom);
      rb  = 4'($urandom);
      run_frame(rtx, rrs, rb[0], rb[1], rb[2], rb[3], 0, 0);
    end

    repeat (5) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
